// File: rtl/glitch_filter.sv
// Glitch filter: two-flop synchroniser followed by a level-acceptance FSM that
// only passes a new level after FILTER_LEN consecutive samples. Optional glitch counter: GLITCH_FILTER_GCOUNT_EN.
module glitch_filter #(
  parameter int   FILTER_LEN  = 4,
  parameter int   GCNT_WIDTH  = 8,
  parameter logic RESET_LEVEL = 1'b0
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  din,
  output logic                  dout,
  output logic                  rise_tick,
  output logic                  fall_tick,
  output logic                  glitch_tick
`ifdef GLITCH_FILTER_GCOUNT_EN
  ,
  input  logic                  gcnt_clr,
  output logic [GCNT_WIDTH-1:0] glitch_count
`endif
);

  localparam int CW = $clog2(FILTER_LEN) + 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(FILTER_LEN - 1);

  typedef enum logic [1:0] {
    ST_LOW    = 2'd0,
    PEND_HIGH = 2'd1,
    ST_HIGH   = 2'd2,
    PEND_LOW  = 2'd3
  } state_t;

  state_t        state_q;
  logic [CW-1:0] cnt_q;
  logic          s1_q;
  logic          s2_q;
  logic          dout_q;
  logic          rise_q;
  logic          fall_q;
  logic          glitch_q;

  // Two-flop synchroniser for the possibly asynchronous input.
  always_ff @(posedge clk) begin
    if (reset) begin
      s1_q <= RESET_LEVEL;
      s2_q <= RESET_LEVEL;
    end else begin
      s1_q <= din;
      s2_q <= s1_q;
    end
  end

  // Level-acceptance FSM; ticks default low so each pulse lasts one cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= RESET_LEVEL ? ST_HIGH : ST_LOW;
      cnt_q    <= '0;
      dout_q   <= RESET_LEVEL;
      rise_q   <= 1'b0;
      fall_q   <= 1'b0;
      glitch_q <= 1'b0;
    end else begin
      rise_q   <= 1'b0;
      fall_q   <= 1'b0;
      glitch_q <= 1'b0;
      case (state_q)
        ST_LOW: begin
          if (s2_q) begin
            state_q <= PEND_HIGH;
            cnt_q   <= CW'(1);
          end else begin
            state_q <= ST_LOW;
          end
        end
        PEND_HIGH: begin
          if (!s2_q) begin
            state_q  <= ST_LOW;
            cnt_q    <= '0;
            glitch_q <= 1'b1;
          end else if (cnt_q == CNT_LAST) begin
            state_q <= ST_HIGH;
            cnt_q   <= '0;
            dout_q  <= 1'b1;
            rise_q  <= 1'b1;
          end else begin
            cnt_q <= cnt_q + CW'(1);
          end
        end
        ST_HIGH: begin
          if (!s2_q) begin
            state_q <= PEND_LOW;
            cnt_q   <= CW'(1);
          end else begin
            state_q <= ST_HIGH;
          end
        end
        PEND_LOW: begin
          if (s2_q) begin
            state_q  <= ST_HIGH;
            cnt_q    <= '0;
            glitch_q <= 1'b1;
          end else if (cnt_q == CNT_LAST) begin
            state_q <= ST_LOW;
            cnt_q   <= '0;
            dout_q  <= 1'b0;
            fall_q  <= 1'b1;
          end else begin
            cnt_q <= cnt_q + CW'(1);
          end
        end
        default: begin
          state_q <= RESET_LEVEL ? ST_HIGH : ST_LOW;
          cnt_q   <= '0;
        end
      endcase
    end
  end

`ifdef GLITCH_FILTER_GCOUNT_EN
  logic                  glitch_event_s;
  logic [GCNT_WIDTH-1:0] gcnt_q;

  // Same condition that raises glitch_tick, so the count moves with the tick.
  assign glitch_event_s = ((state_q == PEND_HIGH) && !s2_q) ||
                          ((state_q == PEND_LOW)  &&  s2_q);

  // Saturating rejected-pulse counter; clear has priority over increment.
  always_ff @(posedge clk) begin
    if (reset || gcnt_clr) begin
      gcnt_q <= '0;
    end else if (glitch_event_s && (gcnt_q != {GCNT_WIDTH{1'b1}})) begin
      gcnt_q <= gcnt_q + GCNT_WIDTH'(1);
    end else begin
      gcnt_q <= gcnt_q;
    end
  end

  assign glitch_count = gcnt_q;
`endif

  assign dout        = dout_q;
  assign rise_tick   = rise_q;
  assign fall_tick   = fall_q;
  assign glitch_tick = glitch_q;

endmodule

// File: tb/tb_glitch_filter.sv
// Randomised bench for glitch_filter with a run-length reference model.
module tb_glitch_filter;
  localparam int   FL = 4;
  localparam logic RL = 1'b0;
`ifdef GLITCH_FILTER_GCOUNT_EN
  localparam int   GW = 2;
`endif

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic din = 1'b0;
  logic dout, rise_tick, fall_tick, glitch_tick;
`ifdef GLITCH_FILTER_GCOUNT_EN
  logic          gcnt_clr = 1'b0;
  logic [GW-1:0] glitch_count;
`endif

  always #5 clk = ~clk;

  glitch_filter #(
    .FILTER_LEN (FL),
`ifdef GLITCH_FILTER_GCOUNT_EN
    .GCNT_WIDTH (GW),
`endif
    .RESET_LEVEL(RL)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .din        (din),
    .dout       (dout),
    .rise_tick  (rise_tick),
    .fall_tick  (fall_tick),
    .glitch_tick(glitch_tick)
`ifdef GLITCH_FILTER_GCOUNT_EN
    ,
    .gcnt_clr   (gcnt_clr),
    .glitch_count(glitch_count)
`endif
  );

  int n_chk = 0;
  int n_pass = 0;

  // Reference model: din history delayed two clocks, plus length of the
  // current run of samples that disagree with the accepted level.
  logic m_s1 = RL, m_s2 = RL, m_dout = RL;
  logic m_rise = 1'b0, m_fall = 1'b0, m_glt = 1'b0;
  int   m_run = 0;
  int   m_gc = 0;

  task automatic check_eq(input string tag, input int obs, input int exp);
    n_chk++;
    if (obs == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
  endtask

  task automatic step(input logic d, input logic r, input logic clr);
    logic samp;
    @(negedge clk);
    din   = d;
    reset = r;
`ifdef GLITCH_FILTER_GCOUNT_EN
    gcnt_clr = clr;
`endif
    @(posedge clk);
    #1;
    m_rise = 1'b0; m_fall = 1'b0; m_glt = 1'b0;
    if (r) begin
      m_s1 = RL; m_s2 = RL; m_dout = RL; m_run = 0; m_gc = 0;
    end else begin
      samp = m_s2;
      m_s2 = m_s1;
      m_s1 = d;
      if (samp != m_dout) begin
        m_run++;
        if (m_run == FL) begin
          m_dout = samp;
          m_rise = samp;
          m_fall = !samp;
          m_run  = 0;
        end
      end else if (m_run > 0) begin
        m_glt = 1'b1;
        m_run = 0;
      end
`ifdef GLITCH_FILTER_GCOUNT_EN
      if (clr) m_gc = 0;
      else if (m_glt && m_gc < (1 << GW) - 1) m_gc++;
`endif
    end
    check_eq("dout", int'(dout), int'(m_dout));
    check_eq("rise_tick", int'(rise_tick), int'(m_rise));
    check_eq("fall_tick", int'(fall_tick), int'(m_fall));
    check_eq("glitch_tick", int'(glitch_tick), int'(m_glt));
`ifdef GLITCH_FILTER_GCOUNT_EN
    check_eq("glitch_count", int'(glitch_count), m_gc);
`endif
  endtask

  // Holds din=1 and reports on which edge rise_tick first appears.
  task automatic run_latency(input string tag);
    int hit;
    hit = -1;
    for (int i = 1; i <= 12; i++) begin
      step(1'b1, 1'b0, 1'b0);
      if (rise_tick && hit < 0) hit = i;
    end
    check_eq(tag, hit, FL + 2);
  endtask

  int gl_cnt;
  int edge_cnt;
  int zl;
  int ol;
  int run_len;
  logic lvl;

  initial begin
    // Reset with din high: nothing may leak through.
    step(1'b1, 1'b1, 1'b0);
    step(1'b1, 1'b1, 1'b0);
    check_eq("reset_dout", int'(dout), int'(RL));
    run_latency("latency_after_reset");

    for (int i = 0; i < 10; i++) step(1'b0, 1'b0, 1'b0);
    check_eq("fell_low", int'(dout), 0);

    // Three-clock pulse is rejected exactly once.
    step(1'b0, 1'b0, 1'b1);
    gl_cnt = 0;
    for (int i = 0; i < 11; i++) begin
      step((i < 3) ? 1'b1 : 1'b0, 1'b0, 1'b0);
      if (glitch_tick) gl_cnt++;
      check_eq("short_pulse_dout", int'(dout), 0);
    end
    check_eq("short_pulse_glitches", gl_cnt, 1);
`ifdef GLITCH_FILTER_GCOUNT_EN
    check_eq("short_pulse_gcount", int'(glitch_count), 1);
`endif

    // Alternating input never produces an edge.
    edge_cnt = 0;
    for (int i = 0; i < 40; i++) begin
      step(i[0] ? 1'b0 : 1'b1, 1'b0, 1'b0);
      if (rise_tick || fall_tick) edge_cnt++;
    end
    check_eq("alternate_edges", edge_cnt, 0);
    for (int i = 0; i < 6; i++) step(1'b0, 1'b0, 1'b0);

`ifdef GLITCH_FILTER_GCOUNT_EN
    // Saturation, then clear colliding with a glitch.
    step(1'b0, 1'b0, 1'b1);
    for (int p = 0; p < 5; p++)
      for (int i = 0; i < 6; i++) step((i < 2) ? 1'b1 : 1'b0, 1'b0, 1'b0);
    check_eq("gcount_saturated", int'(glitch_count), 3);
    for (int i = 1; i <= 5; i++) step((i <= 2) ? 1'b1 : 1'b0, 1'b0, (i == 5) ? 1'b1 : 1'b0);
    check_eq("clr_vs_glitch_tick", int'(glitch_tick), 1);
    check_eq("clr_wins", int'(glitch_count), 0);
    for (int i = 0; i < 4; i++) step(1'b0, 1'b0, 1'b0);
`endif

    // Reset one cycle after entering PEND_HIGH drops the pending change.
    for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b1, 1'b0);
    check_eq("pend_reset_glitch", int'(glitch_tick), 0);
    check_eq("pend_reset_dout", int'(dout), int'(RL));
    run_latency("latency_after_pend_reset");

    // Mux-hazard style: stable 1 with short zero spikes keeps dout high.
    for (int p = 0; p < 15; p++) begin
      zl = $urandom_range(FL - 1, 1);
      ol = $urandom_range(4, 1);
      for (int i = 0; i < zl + ol; i++) begin
        step((i < zl) ? 1'b0 : 1'b1, 1'b0, 1'b0);
        check_eq("hazard_dout_high", int'(dout), 1);
      end
    end

    // Random runs of varied length with occasional reset and clear.
    lvl = 1'b0;
    for (int p = 0; p < 80; p++) begin
      run_len = $urandom_range(7, 1);
      lvl = ~lvl;
      for (int i = 0; i < run_len; i++)
        step(lvl, ($urandom_range(99, 0) == 0) ? 1'b1 : 1'b0,
             ($urandom_range(19, 0) == 0) ? 1'b1 : 1'b0);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
